// File: rtl/req_master_fsm.sv
// req_master_fsm: initiator side of an 8-bit four-phase req/ack byte handshake.
// Bytes are queued into a DEPTH-entry transmit FIFO and sent one at a time, in order.
// Optional feature macro: REQ_TIMEOUT_EN adds a watchdog that abandons a byte whose
// ack never arrives and pulses err; without it err is tied to 0.
module req_master_fsm #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       ack,
  output logic       req,
  output logic [7:0] data_out,
  output logic       busy,
  output logic [7:0] sent_count,
  output logic       err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    sent_q, sent_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;
  logic timeout_hit;

  // full is taken from the registered count, so a push while full is dropped
  // even when a pop happens in the same cycle.
  assign full = (count_q == DepthC);
  assign push = wr_en & ~full;

`ifdef REQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_q, wd_d;
  logic       err_q;

  // Abort only when no ack is seen on the final watchdog edge; ack wins a tie.
  assign timeout_hit = (state_q == REQ) && !ack && (wd_q == TimeoutLast);

  // Watchdog counts ack-less cycles in REQ and sits at zero elsewhere, so it is
  // already cleared on every entry to REQ.
  always_comb begin
    wd_d = 8'd0;
    if (state_q == REQ && !ack) begin
      wd_d = wd_q + 8'd1;
    end
  end

  // Watchdog counter and registered one-cycle err pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // Handshake FSM: pop in IDLE, hold in REQ until ack, wait for ack release in REL.
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (ack) begin
          req_d   = 1'b0;
          sent_d  = sent_q + 8'd1;
          state_d = REL;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        // A trailing ack must drop before the next byte may be offered.
        req_d = 1'b0;
        if (!ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      data_q   <= 8'd0;
      sent_q   <= 8'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      sent_q   <= sent_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign req        = req_q;
  assign data_out   = data_q;
  assign sent_count = sent_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_req_master_fsm.sv
// Bench for req_master_fsm: scenario tasks with inline checks, plus a byte
// scoreboard (expected bytes queued at stimulus time, observed bytes captured on
// each req rise). Timeout scenarios are built only with REQ_TIMEOUT_EN.
module tb_req_master_fsm;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       ack;
  logic       req;
  logic [7:0] data_out;
  logic       busy;
  logic [7:0] sent_count;
  logic       err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_sent = 8'd0;

  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];

  // Responder model: ack rises two cycles after req is first sampled, lasts resp_len.
  logic resp_en = 1'b0;
  logic resp_ack = 1'b0;
  logic man_ack = 1'b0;
  int   resp_len = 2;
  int   resp_phase = 0;
  int   resp_cnt = 0;

  // Monitor state.
  logic       req_prev = 1'b0;
  logic [7:0] held = 8'd0;
  logic       hold_bad = 1'b0;
  int         rises = 0;

  assign ack = resp_ack | man_ack;

  always #5 clk = ~clk;

  req_master_fsm #(
    .DEPTH         (Depth),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .ack       (ack),
    .req       (req),
    .data_out  (data_out),
    .busy      (busy),
    .sent_count(sent_count),
    .err       (err)
  );

  // Registered responder.
  always @(posedge clk) begin
    if (!resp_en) begin
      resp_phase <= 0;
      resp_ack   <= 1'b0;
    end else begin
      case (resp_phase)
        0: if (req) resp_phase <= 1;
        1: begin
          resp_ack   <= 1'b1;
          resp_cnt   <= resp_len - 1;
          resp_phase <= 2;
        end
        2: begin
          if (resp_cnt == 0) begin
            resp_ack   <= 1'b0;
            resp_phase <= 3;
          end else begin
            resp_cnt <= resp_cnt - 1;
          end
        end
        default: if (!req) resp_phase <= 0;
      endcase
    end
  end

  // Capture the byte on every req rise and flag data_out moving while req is held.
  always @(negedge clk) begin
    if (req && !req_prev) begin
      obs_q.push_back(data_out);
      rises <= rises + 1;
    end
    if (req && req_prev && data_out !== held) hold_bad <= 1'b1;
    req_prev <= req;
    held     <= data_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b want 0", req); end
    n_checks++; if (data_out !== 8'd0) begin n_errors++; $display("FAIL reset_data got %h want 00", data_out); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (sent_count !== 8'd0) begin n_errors++; $display("FAIL reset_sent got %0d want 0", sent_count); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
    step();
    rst = 1'b1;
    step();
    exp_sent = 8'd0;
  endtask

  // Push at cycle 0: req high in cycles 2-4, count at cycle 5, idle by cycle 7.
  task automatic test_single_byte();
    logic [7:0] base;
    logic       exp_req;
    logic       exp_busy;
    base     = exp_sent;
    resp_len = 2;
    resp_en  = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_req  = (c >= 2 && c <= 4);
      exp_busy = (c >= 1 && c <= 6);
      n_checks++;
      if (req !== exp_req) begin
        n_errors++; $display("FAIL single_req cycle %0d got %b want %b", c, req, exp_req);
      end
      if (exp_req) begin
        n_checks++;
        if (data_out !== 8'hA5) begin
          n_errors++; $display("FAIL single_data cycle %0d got %h want a5", c, data_out);
        end
      end
      n_checks++;
      if (sent_count !== ((c >= 5) ? base + 8'd1 : base)) begin
        n_errors++; $display("FAIL single_sent cycle %0d got %0d want %0d", c, sent_count,
                             (c >= 5) ? base + 8'd1 : base);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++; $display("FAIL single_busy cycle %0d got %b want %b", c, busy, exp_busy);
      end
      step();
      wr_en = 1'b0;
    end
    exp_sent = base + 8'd1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL single_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL single_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // A leading byte is parked in REL (ack held) while four bytes fill the FIFO;
  // the fifth push lands on the cycle the FSM pops and must be dropped.
  task automatic test_burst_full();
    logic [7:0] base;
    int         r0;
    bit         seen;
    bit         done;
    base    = exp_sent;
    r0      = rises;
    resp_en = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    exp_q.push_back(8'hEE);
    step();
    wr_en = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      seen = req;
      step();
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL burst_lead_req got 0 want 1 within 6 cycles"); end
    man_ack = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (sent_count !== base + 8'd1) begin
      n_errors++; $display("FAIL burst_lead_sent got %0d want %0d", sent_count, base + 8'd1);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      // Four slots free and no pop until the FSM leaves REL, so only 0x01..0x04 fit.
      if (i < 4) exp_q.push_back(8'(i + 1));
      if (i == 3) man_ack = 1'b0;
      @(negedge clk);
      if (i >= 3) begin
        n_checks++;
        if (full !== (i == 4)) begin
          n_errors++; $display("FAIL burst_full push %0d got %b want %b", i, full, i == 4);
        end
      end
      step();
    end
    wr_en   = 1'b0;
    resp_en = 1'b1;
    done    = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      done = !busy;
      step();
    end
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL burst_drain busy got 1 want 0 within 60 cycles"); end
    n_checks++;
    if (sent_count !== base + 8'd5) begin
      n_errors++; $display("FAIL burst_sent got %0d want %0d", sent_count, base + 8'd5);
    end
    n_checks++;
    if (rises - r0 != 5) begin
      n_errors++; $display("FAIL burst_rises got %0d want 5", rises - r0);
    end
    n_checks++;
    if (hold_bad !== 1'b0) begin n_errors++; $display("FAIL burst_hold got 1 want 0"); end
    exp_sent = base + 8'd5;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL burst_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL burst_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Five-cycle ack: req must overlap ack only on the first sampled ack cycle.
  task automatic test_long_ack();
    logic [7:0] base;
    int         r0;
    int         overlap;
    bit         done;
    base     = exp_sent;
    r0       = rises;
    resp_len = 5;
    resp_en  = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    wr_data = 8'h6B;
    exp_q.push_back(8'h6B);
    step();
    wr_en   = 1'b0;
    overlap = 0;
    done    = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (req && ack) overlap++;
      done = !busy;
      step();
    end
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL long_drain busy got 1 want 0 within 60 cycles"); end
    n_checks++;
    if (overlap != 2) begin n_errors++; $display("FAIL long_overlap got %0d want 2", overlap); end
    n_checks++;
    if (rises - r0 != 2) begin n_errors++; $display("FAIL long_rises got %0d want 2", rises - r0); end
    n_checks++;
    if (sent_count !== base + 8'd2) begin
      n_errors++; $display("FAIL long_sent got %0d want %0d", sent_count, base + 8'd2);
    end
    exp_sent = base + 8'd2;
    resp_len = 2;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL long_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL long_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef REQ_TIMEOUT_EN
  // No ack for the first byte: req high exactly Timeout cycles, one err pulse,
  // then the second byte goes through with the responder re-enabled.
  task automatic test_timeout();
    logic [7:0] base;
    int         hi;
    int         errs;
    bit         first_done;
    bit         done;
    base    = exp_sent;
    resp_en = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    exp_q.push_back(8'h3C);
    step();
    wr_data = 8'h4D;
    exp_q.push_back(8'h4D);
    step();
    wr_en      = 1'b0;
    hi         = 0;
    errs       = 0;
    first_done = 1'b0;
    done       = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!first_done) begin
        if (req) begin
          hi++;
        end else if (hi > 0) begin
          first_done = 1'b1;
          n_checks++;
          if (err !== 1'b1) begin n_errors++; $display("FAIL to_err_on_drop got %b want 1", err); end
        end
      end
      if (err) errs++;
      done = first_done && !busy;
      step();
      if (first_done) resp_en = 1'b1;
    end
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL to_drain busy got 1 want 0 within 60 cycles"); end
    n_checks++;
    if (hi != Timeout) begin n_errors++; $display("FAIL to_req_len got %0d want %0d", hi, Timeout); end
    n_checks++;
    if (errs != 1) begin n_errors++; $display("FAIL to_err_count got %0d want 1", errs); end
    n_checks++;
    if (sent_count !== base + 8'd1) begin
      n_errors++; $display("FAIL to_sent got %0d want %0d", sent_count, base + 8'd1);
    end
    exp_sent = base + 8'd1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL to_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL to_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Ack arrives on the very edge the watchdog would abort: the byte counts, no err.
  task automatic test_ack_at_timeout();
    logic [7:0] base;
    int         hi;
    int         errs;
    base    = exp_sent;
    resp_en = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    exp_q.push_back(8'h77);
    step();
    wr_en = 1'b0;
    hi    = 0;
    errs  = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (req) hi++;
      if (err) errs++;
      man_ack = req && (hi == Timeout);
    end
    man_ack = 1'b0;
    step();
    n_checks++;
    if (hi != Timeout) begin n_errors++; $display("FAIL tie_req_len got %0d want %0d", hi, Timeout); end
    n_checks++;
    if (errs != 0) begin n_errors++; $display("FAIL tie_err got %0d want 0", errs); end
    n_checks++;
    if (sent_count !== base + 8'd1) begin
      n_errors++; $display("FAIL tie_sent got %0d want %0d", sent_count, base + 8'd1);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL tie_busy got %b want 0", busy); end
    exp_sent = base + 8'd1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL tie_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL tie_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  // Reset mid-transfer with three bytes queued: everything clears at once,
  // nothing is sent until a fresh push.
  task automatic test_reset_mid();
    bit bad_req;
    bit done;
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hC1 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    // Only 0xC1 reaches req before reset; 0xC2..0xC4 are lost.
    exp_q.push_back(8'hC1);
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_req got %b want 1", req); end
    #1;
    rst = 1'b0;
    #1;
    exp_sent = 8'd0;
    n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL rmid_req got %b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_checks++;
    if (sent_count !== 8'd0) begin n_errors++; $display("FAIL rmid_sent got %0d want 0", sent_count); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL rmid_full got %b want 0", full); end
    step();
    step();
    rst     = 1'b1;
    bad_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req || busy) bad_req = 1'b1;
      step();
    end
    n_checks++;
    if (bad_req) begin n_errors++; $display("FAIL rmid_quiet got req/busy 1 want 0 after release"); end
    resp_en = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hD1;
    exp_q.push_back(8'hD1);
    step();
    wr_en = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      done = !busy;
      step();
    end
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL rmid_drain busy got 1 want 0 within 30 cycles"); end
    n_checks++;
    if (sent_count !== 8'd1) begin n_errors++; $display("FAIL rmid_after_sent got %0d want 1", sent_count); end
    exp_sent = 8'd1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rmid_sb_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL rmid_sb got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'd0;
    test_reset();
    test_single_byte();
    test_burst_full();
    test_long_ack();
`ifdef REQ_TIMEOUT_EN
    test_timeout();
    test_ack_at_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
